// File: rtl/c4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c4_pkg
//  Description : Shared constants, cell codes and checker state encoding
//                for the connect-four line checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package c4_pkg;

  localparam int BOARD_CELLS = 42;
  localparam int ROWS        = 6;
  localparam int COLS        = 7;
  localparam int NUM_LINES   = 69;

  localparam int POS_W  = 6;   // board address width (0..41)
  localparam int LINE_W = 7;   // line index width (0..68)

  // Cell codes as seen on the board read port; 2'b11 is folded to EMPTY.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/four_row_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : four_row_checker_if
//  Description : Request / board-read / result bundle between a game
//                controller (master) and the four-in-a-row checker (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface four_row_checker_if;
  import c4_pkg::*;

  logic              start;
  logic [POS_W-1:0]  rd_pos;
  logic [1:0]        rd_data;
  logic              busy;
  logic              done;
  logic              p1_four_row;
  logic              p2_four_row;
  logic              tie_game;

  modport master (
    output start,
    output rd_data,
    input  rd_pos,
    input  busy,
    input  done,
    input  p1_four_row,
    input  p2_four_row,
    input  tie_game
  );

  modport slave (
    input  start,
    input  rd_data,
    output rd_pos,
    output busy,
    output done,
    output p1_four_row,
    output p2_four_row,
    output tie_game
  );

endinterface
`default_nettype wire

// File: rtl/c4_line_rom.sv
`default_nettype none
// ============================================================================
//  Module      : c4_line_rom
//  Description : Maps a line index (0..68) to the base cell and stride of the
//                four cells forming that line. cell = col*6 + row.
//                 0-20 vertical, 21-44 horizontal, 45-56 diagonal up,
//                57-68 diagonal down. Out-of-range indices give base 0,
//                step 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module c4_line_rom
  import c4_pkg::*;
(
  input  logic [LINE_W-1:0] line_idx,
  output logic [POS_W-1:0]  base,
  output logic [2:0]        step
);

  logic [LINE_W-1:0] k;
  logic [2:0]        col;
  logic [2:0]        row;

  // Decode the line group, then split the group offset into start col/row.
  always_comb begin
    k    = '0;
    col  = '0;
    row  = '0;
    step = 3'd0;
    if (line_idx < 7'd21) begin
      k    = line_idx;
      col  = 3'(k / 7'd3);
      row  = 3'(k % 7'd3);
      step = 3'd1;
    end else if (line_idx < 7'd45) begin
      k    = line_idx - 7'd21;
      row  = 3'(k / 7'd4);
      col  = 3'(k % 7'd4);
      step = 3'd6;
    end else if (line_idx < 7'd57) begin
      k    = line_idx - 7'd45;
      col  = 3'(k / 7'd3);
      row  = 3'(k % 7'd3);
      step = 3'd7;
    end else if (line_idx < 7'd69) begin
      k    = line_idx - 7'd57;
      col  = 3'(k / 7'd3);
      row  = 3'(k % 7'd3) + 3'd3;
      step = 3'd5;
    end
    base = {3'b000, col} * 6'd6 + {3'b000, row};
  end

endmodule
`default_nettype wire

// File: rtl/four_row_checker.sv
`default_nettype none
// ============================================================================
//  Module      : four_row_checker
//  Description : On start, copies the 42-cell board into a shadow register
//                file (one cell per cycle), then walks all 69 possible lines
//                of four (one per cycle, no early exit) and reports per-player
//                wins and a tie. done pulses 112 cycles after start.
//  Revision    : 1.0 - initial release
// ============================================================================
module four_row_checker
  import c4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,      // asynchronous, active low
  four_row_checker_if.slave bus
);

  chk_state_t        state_q, state_d;
  logic [POS_W-1:0]  pos_q,   pos_d;
  logic [LINE_W-1:0] line_q,  line_d;
  logic [1:0]        board_q [BOARD_CELLS];
  logic [1:0]        board_d [BOARD_CELLS];
  logic              p1_hit_q, p1_hit_d;
  logic              p2_hit_q, p2_hit_d;
  logic              p1_flag_q, p1_flag_d;
  logic              p2_flag_q, p2_flag_d;
  logic              tie_q, tie_d;

  logic [POS_W-1:0]  line_base;
  logic [2:0]        line_step;
  logic [POS_W-1:0]  a1, a2, a3;
  logic [1:0]        c0, c1, c2, c3;
  logic              line_p1, line_p2;
  logic              board_full;
  logic [1:0]        cap_cell;
  logic              any_p1, any_p2;

  c4_line_rom u_line_rom (
    .line_idx (line_q),
    .base     (line_base),
    .step     (line_step)
  );

  // Fetch the four shadow cells of the current line and test ownership.
  always_comb begin
    a1      = line_base + {3'b000, line_step};
    a2      = a1 + {3'b000, line_step};
    a3      = a2 + {3'b000, line_step};
    c0      = board_q[line_base];
    c1      = board_q[a1];
    c2      = board_q[a2];
    c3      = board_q[a3];
    line_p1 = (c0 == P1) && (c1 == P1) && (c2 == P1) && (c3 == P1);
    line_p2 = (c0 == P2) && (c1 == P2) && (c2 == P2) && (c3 == P2);
  end

  // A board is full when no shadow cell is empty (code 11 is stored as empty).
  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < BOARD_CELLS; i++) begin
      if (board_q[i] == EMPTY) board_full = 1'b0;
    end
  end

  assign cap_cell = (bus.rd_data == 2'b11) ? EMPTY : bus.rd_data;
  assign any_p1   = p1_hit_q | line_p1;
  assign any_p2   = p2_hit_q | line_p2;

  // Next-state, scan counters, hit accumulation and result flags.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    line_d    = line_q;
    board_d   = board_q;
    p1_hit_d  = p1_hit_q;
    p2_hit_d  = p2_hit_q;
    p1_flag_d = p1_flag_q;
    p2_flag_d = p2_flag_q;
    tie_d     = tie_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_LOAD;
          pos_d     = '0;
          line_d    = '0;
          p1_hit_d  = 1'b0;
          p2_hit_d  = 1'b0;
          p1_flag_d = 1'b0;
          p2_flag_d = 1'b0;
          tie_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        board_d[pos_q] = cap_cell;
        if (pos_q == POS_W'(BOARD_CELLS - 1)) begin
          state_d = ST_EVAL;
          pos_d   = '0;
          line_d  = '0;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      ST_EVAL: begin
        p1_hit_d = any_p1;
        p2_hit_d = any_p2;
        if (line_q == LINE_W'(NUM_LINES - 1)) begin
          // Flags are loaded on entry to DONE so they are valid alongside done.
          state_d   = ST_DONE;
          line_d    = '0;
          p1_flag_d = any_p1;
          p2_flag_d = any_p2;
          tie_d     = board_full & ~any_p1 & ~any_p2;
        end else begin
          line_d = line_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any scan and empties the shadow board.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      line_q    <= '0;
      p1_hit_q  <= 1'b0;
      p2_hit_q  <= 1'b0;
      p1_flag_q <= 1'b0;
      p2_flag_q <= 1'b0;
      tie_q     <= 1'b0;
      for (int i = 0; i < BOARD_CELLS; i++) board_q[i] <= EMPTY;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      line_q    <= line_d;
      p1_hit_q  <= p1_hit_d;
      p2_hit_q  <= p2_hit_d;
      p1_flag_q <= p1_flag_d;
      p2_flag_q <= p2_flag_d;
      tie_q     <= tie_d;
      board_q   <= board_d;
    end
  end

  assign bus.busy        = (state_q == ST_LOAD) || (state_q == ST_EVAL);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.rd_pos      = (state_q == ST_LOAD) ? pos_q : '0;
  assign bus.p1_four_row = p1_flag_q;
  assign bus.p2_four_row = p2_flag_q;
  assign bus.tie_game    = tie_q;

endmodule
`default_nettype wire

// File: tb/tb_four_row_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_four_row_checker
//  Description : Directed self-checking bench for four_row_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_four_row_checker;
  import c4_pkg::*;

  logic clk = 1'b0;
  logic reset;

  four_row_checker_if bus ();

  four_row_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [1:0] board [42];
  assign bus.rd_data = (bus.rd_pos < 6'd42) ? board[bus.rd_pos] : 2'b00;

  int total = 0;
  int bad   = 0;

  // Observations collected by do_scan (cycle k = just after edge k).
  int         done_at, done_cnt;
  logic       f_p1, f_p2, f_tie;
  logic       busy_c1, busy_c112, busy_c113, p1_c1;
  logic [5:0] pos_c1, pos_c42, pos_max;

  task automatic clear_board();
    for (int i = 0; i < 42; i++) board[i] = 2'b00;
  endtask

  task automatic put4(input logic [1:0] v, input int a, input int b, input int c, input int d);
    board[a] = v; board[b] = v; board[c] = v; board[d] = v;
  endtask

  // Pulse start so it is sampled at edge 0, then observe cycles 1..ncyc.
  task automatic do_scan(input int restart_at, input int ncyc);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_at = -1; done_cnt = 0; pos_max = '0;
    f_p1 = 1'bx; f_p2 = 1'bx; f_tie = 1'bx;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = cyc; f_p1 = bus.p1_four_row; f_p2 = bus.p2_four_row; f_tie = bus.tie_game;
        end
      end
      if (bus.rd_pos > pos_max) pos_max = bus.rd_pos;
      if (cyc == 1) begin busy_c1 = bus.busy; pos_c1 = bus.rd_pos; p1_c1 = bus.p1_four_row; end
      if (cyc == 42)  pos_c42   = bus.rd_pos;
      if (cyc == 112) busy_c112 = bus.busy;
      if (cyc == 113) busy_c113 = bus.busy;
      bus.start = (cyc == restart_at);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b0; clear_board();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if ({bus.p1_four_row, bus.p2_four_row, bus.tie_game} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {bus.p1_four_row, bus.p2_four_row, bus.tie_game}); end
    total++; if (bus.rd_pos !== 6'd0) begin bad++; $display("FAIL reset_rdpos got=%0d want=0", bus.rd_pos); end
    reset = 1'b1;
  endtask

  task automatic test_empty();
    clear_board();
    do_scan(0, 116);
    total++; if (done_at != 112) begin bad++; $display("FAIL empty_latency got=%0d want=112", done_at); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL empty_done_pulses got=%0d want=1", done_cnt); end
    total++; if ({f_p1, f_p2, f_tie} !== 3'b000) begin bad++; $display("FAIL empty_flags got=%b want=000", {f_p1, f_p2, f_tie}); end
    total++; if (busy_c1 !== 1'b1) begin bad++; $display("FAIL empty_busy_c1 got=%b want=1", busy_c1); end
    total++; if (busy_c112 !== 1'b0) begin bad++; $display("FAIL empty_busy_done got=%b want=0", busy_c112); end
    total++; if (pos_c1 !== 6'd0) begin bad++; $display("FAIL empty_rdpos_c1 got=%0d want=0", pos_c1); end
    total++; if (pos_c42 !== 6'd41) begin bad++; $display("FAIL empty_rdpos_c42 got=%0d want=41", pos_c42); end
    total++; if (pos_max > 6'd41) begin bad++; $display("FAIL empty_rdpos_max got=%0d want<=41", pos_max); end
  endtask

  task automatic test_vertical();
    clear_board(); put4(P1, 0, 1, 2, 3);
    do_scan(0, 116);
    total++; if (done_at != 112) begin bad++; $display("FAIL vert_latency got=%0d want=112", done_at); end
    total++; if ({f_p1, f_p2, f_tie} !== 3'b100) begin bad++; $display("FAIL vert_flags got=%b want=100", {f_p1, f_p2, f_tie}); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (bus.p1_four_row !== 1'b1) begin bad++; $display("FAIL vert_flag_hold got=%b want=1", bus.p1_four_row); end
    // Next accepted start on an empty board must clear the held flag at once.
    clear_board();
    do_scan(0, 116);
    total++; if (p1_c1 !== 1'b0) begin bad++; $display("FAIL flag_clear_on_start got=%b want=0", p1_c1); end
    total++; if (f_p1 !== 1'b0) begin bad++; $display("FAIL flag_clear_result got=%b want=0", f_p1); end
  endtask

  task automatic test_lines();
    logic [1:0] want;
    for (int t = 0; t < 6; t++) begin
      clear_board();
      case (t)
        0: begin put4(P2, 3, 8, 13, 18);   want = 2'b01; end  // diagonal down
        1: begin put4(P1, 5, 6, 7, 8);     want = 2'b00; end  // wraps column edge
        2: begin put4(P2, 5, 11, 17, 23);  want = 2'b01; end  // top-row horizontal
        3: begin put4(P1, 0, 7, 14, 21);   want = 2'b10; end  // diagonal up
        4: begin put4(P1, 38, 39, 40, 41); put4(P2, 18, 24, 30, 36); want = 2'b11; end
        default: begin put4(P1, 0, 1, 2, 3); board[3] = 2'b11; want = 2'b00; end
      endcase
      do_scan(0, 116);
      total++; if ({f_p1, f_p2} !== want) begin
        bad++; $display("FAIL lines_%0d got=%b want=%b", t, {f_p1, f_p2}, want); end
    end
  endtask

  task automatic test_tie();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        board[c*6 + r] = (((r / 2) + c) % 2 == 0) ? P1 : P2;
    do_scan(0, 116);
    total++; if ({f_p1, f_p2, f_tie} !== 3'b001) begin bad++; $display("FAIL tie_full got=%b want=001", {f_p1, f_p2, f_tie}); end
    board[20] = 2'b11;
    do_scan(0, 116);
    total++; if ({f_p1, f_p2, f_tie} !== 3'b000) begin bad++; $display("FAIL tie_code11_hole got=%b want=000", {f_p1, f_p2, f_tie}); end
  endtask

  task automatic test_start_ignored();
    clear_board();
    do_scan(50, 116);
    total++; if (done_at != 112) begin bad++; $display("FAIL restart_busy_latency got=%0d want=112", done_at); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_busy_pulses got=%0d want=1", done_cnt); end
    do_scan(112, 116);
    total++; if (busy_c113 !== 1'b0) begin bad++; $display("FAIL start_in_done_busy got=%b want=0", busy_c113); end
  endtask

  task automatic test_reset_abort();
    int dcnt;
    clear_board(); put4(P1, 0, 1, 2, 3);
    do_scan(0, 20);
    reset = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    total++; if (bus.rd_pos !== 6'd0) begin bad++; $display("FAIL abort_rdpos got=%0d want=0", bus.rd_pos); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcnt++;
    end
    total++; if (dcnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dcnt); end
    total++; if ({bus.p1_four_row, bus.p2_four_row, bus.tie_game} !== 3'b000) begin
      bad++; $display("FAIL abort_flags got=%b want=000", {bus.p1_four_row, bus.p2_four_row, bus.tie_game}); end
    do_scan(0, 116);
    total++; if (done_at != 112) begin bad++; $display("FAIL abort_rescan_latency got=%0d want=112", done_at); end
    total++; if (f_p1 !== 1'b1) begin bad++; $display("FAIL abort_rescan_p1 got=%b want=1", f_p1); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_vertical();
    test_lines();
    test_tie();
    test_start_ignored();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
